init_fpga: RTL and testbench

INIT_FPGA -- requirements
Module: init_fpga

---
 rtl/init_fpga.sv | 96 +++++++++
 tb/tb_init_fpga.sv | 104 ++++++++++
 2 files changed

// File: rtl/init_fpga.sv
// Power-up sequencer: on a held start request, enables the downstream device,
// releases its reset after RST_MS and raises init_en after INIT_MS.
module init_fpga #(
  parameter int CLKS_PER_MS = 200000,
  parameter int RST_MS      = 200,
  parameter int INIT_MS     = 6200
) (
  input  logic        clk_200m,
  input  logic        locked,
  input  logic        gpio_3,
  input  logic        gpio_2,
  output logic        FPGA_nRESET,
  output logic        init_en,
  output logic        FPGA_EN,
  output logic [19:0] cnt_1ms,
  output logic [15:0] cnt_6200ms
);

  typedef enum logic [1:0] {IDLE, PWR_RST, WAIT_INIT, DONE} state_t;

  localparam logic [19:0] LAST_CLK = 20'(CLKS_PER_MS - 1);
  localparam logic [15:0] RST_CNT  = 16'(RST_MS);
  localparam logic [15:0] INIT_CNT = 16'(INIT_MS);

  state_t      state, state_nxt;
  logic        en_nxt, nrst_nxt, init_nxt;
  logic [19:0] c1_nxt;
  logic [15:0] c6_nxt;
  logic        start;
  logic        ms_tick;
  logic [15:0] c6_inc;

  assign start   = gpio_3 & gpio_2;
  assign ms_tick = (cnt_1ms == LAST_CLK);
  assign c6_inc  = cnt_6200ms + 16'd1;

  // Any drop of either start input falls through to the all-zero IDLE defaults.
  always_comb begin
    state_nxt = IDLE;
    en_nxt    = 1'b0;
    nrst_nxt  = 1'b0;
    init_nxt  = 1'b0;
    c1_nxt    = 20'd0;
    c6_nxt    = 16'd0;
    if (start) begin
      case (state)
        IDLE: begin
          state_nxt = PWR_RST;
          en_nxt    = 1'b1;
        end
        PWR_RST, WAIT_INIT: begin
          state_nxt = state;
          en_nxt    = 1'b1;
          nrst_nxt  = (state == WAIT_INIT);
          c1_nxt    = ms_tick ? 20'd0 : cnt_1ms + 20'd1;
          c6_nxt    = ms_tick ? c6_inc : cnt_6200ms;
          if (state == PWR_RST && ms_tick && c6_inc == RST_CNT) begin
            state_nxt = WAIT_INIT;
            nrst_nxt  = 1'b1;
          end
          if (state == WAIT_INIT && ms_tick && c6_inc == INIT_CNT) begin
            state_nxt = DONE;
            init_nxt  = 1'b1;
          end
        end
        DONE: begin
          state_nxt = DONE;
          en_nxt    = 1'b1;
          nrst_nxt  = 1'b1;
          init_nxt  = 1'b1;
          c6_nxt    = INIT_CNT;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_200m) begin
    if (!locked) begin
      state       <= IDLE;
      FPGA_EN     <= 1'b0;
      FPGA_nRESET <= 1'b0;
      init_en     <= 1'b0;
      cnt_1ms     <= 20'd0;
      cnt_6200ms  <= 16'd0;
    end else begin
      state       <= state_nxt;
      FPGA_EN     <= en_nxt;
      FPGA_nRESET <= nrst_nxt;
      init_en     <= init_nxt;
      cnt_1ms     <= c1_nxt;
      cnt_6200ms  <= c6_nxt;
    end
  end

endmodule

// File: tb/tb_init_fpga.sv
// Directed bench for init_fpga: expected output words are queued as each
// cycle's stimulus is driven and compared once the following edge has passed.
module tb_init_fpga;

  localparam int C = 10;
  localparam int R = 3;
  localparam int I = 8;

  logic        clk_200m = 1'b0;
  logic        locked   = 1'b0;
  logic        gpio_3   = 1'b0;
  logic        gpio_2   = 1'b0;
  logic        FPGA_nRESET, init_en, FPGA_EN;
  logic [19:0] cnt_1ms;
  logic [15:0] cnt_6200ms;

  logic [38:0] sb[$];
  int checks = 0;
  int errors = 0;

  init_fpga #(.CLKS_PER_MS(C), .RST_MS(R), .INIT_MS(I)) dut (
    .clk_200m   (clk_200m),
    .locked     (locked),
    .gpio_3     (gpio_3),
    .gpio_2     (gpio_2),
    .FPGA_nRESET(FPGA_nRESET),
    .init_en    (init_en),
    .FPGA_EN    (FPGA_EN),
    .cnt_1ms    (cnt_1ms),
    .cnt_6200ms (cnt_6200ms)
  );

  always #2.5 clk_200m = ~clk_200m;

  // Expected outputs k edges after the start edge (k = 0 is the start edge).
  function automatic logic [38:0] exp_at(input int k);
    logic [19:0] c1;
    logic [15:0] c6;
    if (k >= C * I) begin
      c1 = 20'd0;
      c6 = 16'(I);
    end else begin
      c1 = 20'(k % C);
      c6 = 16'(k / C);
    end
    return {1'b1, logic'(k >= C * R), logic'(k >= C * I), c1, c6};
  endfunction

  task automatic step(input logic lk, input logic g3, input logic g2,
                      input logic [38:0] expv, input string tag);
    logic [38:0] got, want;
    locked = lk;
    gpio_3 = g3;
    gpio_2 = g2;
    sb.push_back(expv);
    @(posedge clk_200m);
    #1;
    got  = {FPGA_EN, FPGA_nRESET, init_en, cnt_1ms, cnt_6200ms};
    want = sb.pop_front();
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s en/nrst/init/c1/c6 got=%b/%b/%b/%0d/%0d exp=%b/%b/%b/%0d/%0d",
             tag, got[38], got[37], got[36], got[35:16], got[15:0],
             want[38], want[37], want[36], want[35:16], want[15:0]);
    end
    checks++;
    assert ((FPGA_EN || !FPGA_nRESET) && (FPGA_nRESET || !init_en)) else begin
      errors++;
      $error("FAIL %s_order got en/nrst/init=%b/%b/%b exp=no nrst without en, no init without nrst",
             tag, FPGA_EN, FPGA_nRESET, init_en);
    end
  endtask

  initial begin
    // Reset held with both start inputs high.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 39'd0, "reset");
    // Only one start input high.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 39'd0, "single_gpio");

    // Nominal run to DONE, then drop at S+100.
    for (int k = 0; k < 100; k++) step(1'b1, 1'b1, 1'b1, exp_at(k), "nominal");
    step(1'b1, 1'b0, 1'b0, 39'd0, "post_done_drop");
    step(1'b1, 1'b0, 1'b0, 39'd0, "idle_after_drop");

    // One-cycle abort at S+45, then full restart.
    for (int k = 0; k < 45; k++) step(1'b1, 1'b1, 1'b1, exp_at(k), "pre_abort");
    step(1'b1, 1'b0, 1'b0, 39'd0, "abort");
    for (int k = 0; k < 86; k++) step(1'b1, 1'b1, 1'b1, exp_at(k), "restart_abort");

    // Drop just one input from DONE.
    step(1'b1, 1'b1, 1'b0, 39'd0, "done_drop_one");

    // One-cycle reset at S+50 with start held, restart on the next edge.
    for (int k = 0; k < 50; k++) step(1'b1, 1'b1, 1'b1, exp_at(k), "pre_reset");
    step(1'b0, 1'b1, 1'b1, 39'd0, "mid_reset");
    for (int k = 0; k < 86; k++) step(1'b1, 1'b1, 1'b1, exp_at(k), "restart_reset");
    step(1'b1, 1'b0, 1'b1, 39'd0, "final_drop");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
